// File: rtl/watch_pkg.sv
// Shared constants for the watch time/date blocks: field indices, byte offsets,
// per-field legal ranges, the editor state encoding and a wrap-around step helper.
package watch_pkg;

    localparam int TIME_W = 48;

    localparam logic [2:0] FLD_YEAR   = 3'd0;
    localparam logic [2:0] FLD_MONTH  = 3'd1;
    localparam logic [2:0] FLD_DAY    = 3'd2;
    localparam logic [2:0] FLD_HOUR   = 3'd3;
    localparam logic [2:0] FLD_MINUTE = 3'd4;
    localparam logic [2:0] FLD_SECOND = 3'd5;

    localparam int OFS_YEAR   = 40;
    localparam int OFS_MONTH  = 32;
    localparam int OFS_DAY    = 24;
    localparam int OFS_HOUR   = 16;
    localparam int OFS_MINUTE = 8;
    localparam int OFS_SECOND = 0;

    localparam logic [7:0] YEAR_MIN   = 8'd0;
    localparam logic [7:0] YEAR_MAX   = 8'd255;
    localparam logic [7:0] MONTH_MIN  = 8'd1;
    localparam logic [7:0] MONTH_MAX  = 8'd12;
    localparam logic [7:0] DAY_MIN    = 8'd1;
    localparam logic [7:0] HOUR_MIN   = 8'd0;
    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINSEC_MIN = 8'd0;
    localparam logic [7:0] MINSEC_MAX = 8'd59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EDIT,
        ST_COMMIT
    } state_e;

    function automatic int fld_ofs(input logic [2:0] f);
        case (f)
            FLD_YEAR:   return OFS_YEAR;
            FLD_MONTH:  return OFS_MONTH;
            FLD_DAY:    return OFS_DAY;
            FLD_HOUR:   return OFS_HOUR;
            FLD_MINUTE: return OFS_MINUTE;
            default:    return OFS_SECOND;
        endcase
    endfunction

    // Out-of-range values snap to the minimum rather than stepping from garbage.
    function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] lo,
                                              input logic [7:0] hi, input logic up);
        if (v < lo || v > hi) return lo;
        if (up) return (v == hi) ? lo : v + 8'd1;
        return (v == lo) ? hi : v - 8'd1;
    endfunction

endpackage

// File: rtl/watch_max_day.sv
// Days in a month for the watch calendar; February is 29 in years divisible by 4
// only when WATCH_LEAP_YEAR_EN is defined, otherwise always 28.
module watch_max_day
    import watch_pkg::*;
(
    input  logic [7:0] month_i,
    input  logic [7:0] year_i,
    output logic [7:0] max_day_o
);

`ifndef WATCH_LEAP_YEAR_EN
    logic unused_year;
    assign unused_year = ^year_i;
`endif

    always_comb begin
        max_day_o = 8'd31;
        case (month_i)
            8'd4, 8'd6, 8'd9, 8'd11: max_day_o = 8'd30;
            8'd2: begin
`ifdef WATCH_LEAP_YEAR_EN
                max_day_o = (year_i[1:0] == 2'b00) ? 8'd29 : 8'd28;
`else
                max_day_o = 8'd28;
`endif
            end
            default: max_day_o = 8'd31;
        endcase
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Button-driven time/date editor feeding the watch_date load port.
// February leap handling follows WATCH_LEAP_YEAR_EN through watch_max_day.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk1sec,
    input  logic              btn_mode,
    input  logic              btn_sel,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [TIME_W-1:0] cur_time,
    output logic              set_time,
    output logic [TIME_W-1:0] bin_time,
    output logic              edit_active,
    output logic [2:0]        edit_field,
    output logic              blink
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_SEC);

    state_e            state_q, state_d;
    logic [TIME_W-1:0] shadow_q, shadow_d;
    logic [TIME_W-1:0] bin_q, bin_d;
    logic [2:0]        field_q, field_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              blink_q, blink_d;

    logic [TIME_W-1:0] adj;
    logic [7:0]        cur_max, new_max, fld_val, lo, hi;
    int                ofs;

    // cur_max bounds a day edit; new_max checks the day after a month/year edit.
    watch_max_day u_cur_max (
        .month_i  (shadow_q[OFS_MONTH +: 8]),
        .year_i   (shadow_q[OFS_YEAR +: 8]),
        .max_day_o(cur_max)
    );

    watch_max_day u_new_max (
        .month_i  (adj[OFS_MONTH +: 8]),
        .year_i   (adj[OFS_YEAR +: 8]),
        .max_day_o(new_max)
    );

    always_comb begin
        ofs     = fld_ofs(field_q);
        fld_val = shadow_q[ofs +: 8];
        case (field_q)
            FLD_YEAR:  begin lo = YEAR_MIN;   hi = YEAR_MAX;   end
            FLD_MONTH: begin lo = MONTH_MIN;  hi = MONTH_MAX;  end
            FLD_DAY:   begin lo = DAY_MIN;    hi = cur_max;    end
            FLD_HOUR:  begin lo = HOUR_MIN;   hi = HOUR_MAX;   end
            default:   begin lo = MINSEC_MIN; hi = MINSEC_MAX; end
        endcase
        adj            = shadow_q;
        adj[ofs +: 8]  = step_field(fld_val, lo, hi, btn_up);
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bin_d    = bin_q;
        field_d  = field_q;
        cnt_d    = cnt_q;
        blink_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_mode) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shadow_d = cur_time;
                field_d  = FLD_YEAR;
                cnt_d    = 8'd0;
                blink_d  = 1'b1;
                state_d  = ST_EDIT;
            end
            ST_EDIT: begin
                blink_d = blink_q;
                if (btn_mode) begin
                    bin_d   = shadow_q;
                    cnt_d   = 8'd0;
                    blink_d = 1'b0;
                    state_d = ST_COMMIT;
                end else if (btn_sel) begin
                    field_d = (field_q == FLD_SECOND) ? FLD_YEAR : field_q + 3'd1;
                    cnt_d   = 8'd0;
                    blink_d = 1'b1;
                end else if (btn_up || btn_down) begin
                    shadow_d = adj;
                    if ((field_q == FLD_YEAR || field_q == FLD_MONTH) &&
                        adj[OFS_DAY +: 8] > new_max)
                        shadow_d[OFS_DAY +: 8] = new_max;
                    cnt_d   = 8'd0;
                    blink_d = 1'b1;
                end else if (clk1sec) begin
                    if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                        cnt_d   = 8'd0;
                        blink_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        blink_d = ~blink_q;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            bin_q    <= '0;
            field_q  <= FLD_YEAR;
            cnt_q    <= 8'd0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bin_q    <= bin_d;
            field_q  <= field_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
        end
    end

    assign set_time    = (state_q == ST_COMMIT);
    assign bin_time    = bin_q;
    assign edit_active = (state_q == ST_LOAD) || (state_q == ST_EDIT);
    assign edit_field  = field_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed scenarios plus randomized edit
// sessions compared cycle by cycle against a field-level calendar model.
module tb_watch_set_ctrl;

    localparam int TO = 3;
    localparam int P_IDLE = 0, P_LOAD = 1, P_EDIT = 2, P_COMMIT = 3;

`ifdef WATCH_LEAP_YEAR_EN
    localparam int FEB24 = 29;
`else
    localparam int FEB24 = 28;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk1sec = 1'b0;
    logic        btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [47:0] cur_time = '0;
    logic        set_time;
    logic [47:0] bin_time;
    logic        edit_active;
    logic [2:0]  edit_field;
    logic        blink;

    int checks = 0;
    int fails  = 0;

    int          m_phase;
    logic [7:0]  m_fld [6];
    int          m_sel;
    logic        m_blink;
    int          m_secs;
    logic [47:0] m_bin;

    watch_set_ctrl #(.TIMEOUT_SEC(TO)) dut (
        .clk(clk), .rst(rst), .clk1sec(clk1sec),
        .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_up(btn_up), .btn_down(btn_down),
        .cur_time(cur_time), .set_time(set_time), .bin_time(bin_time),
        .edit_active(edit_active), .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] tpack(input int y, input int mo, input int d,
                                          input int h, input int mi, input int s);
        return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    function automatic int days_in(input int month, input int year);
        if (month == 4 || month == 6 || month == 9 || month == 11) return 30;
`ifdef WATCH_LEAP_YEAR_EN
        if (month == 2) return (year % 4 == 0) ? 29 : 28;
`else
        if (month == 2) return (year < 0) ? 0 : 28;
`endif
        return 31;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        for (int i = 0; i < 6; i++) m_fld[i] = 8'd0;
        m_sel = 0; m_blink = 1'b0; m_secs = 0; m_bin = '0;
    endtask

    task automatic model_adjust(input int dir);
        int lo, hi, span, v;
        lo = 0; hi = 59;
        case (m_sel)
            0: hi = 255;
            1: begin lo = 1; hi = 12; end
            2: begin lo = 1; hi = days_in(int'(m_fld[1]), int'(m_fld[0])); end
            3: hi = 23;
            default: hi = 59;
        endcase
        v = int'(m_fld[m_sel]);
        span = hi - lo + 1;
        if (v < lo || v > hi) v = lo;
        else v = lo + (v - lo + span + dir) % span;
        m_fld[m_sel] = 8'(v);
        if (m_sel < 2 && int'(m_fld[2]) > days_in(int'(m_fld[1]), int'(m_fld[0])))
            m_fld[2] = 8'(days_in(int'(m_fld[1]), int'(m_fld[0])));
    endtask

    task automatic model_step(input logic m, input logic s, input logic u,
                              input logic d, input logic sec);
        case (m_phase)
            P_IDLE: if (m) m_phase = P_LOAD;
            P_LOAD: begin
                for (int i = 0; i < 6; i++) m_fld[i] = cur_time[(5 - i) * 8 +: 8];
                m_sel = 0; m_blink = 1'b1; m_secs = 0; m_phase = P_EDIT;
            end
            P_EDIT: begin
                if (m) begin
                    m_bin = {m_fld[0], m_fld[1], m_fld[2], m_fld[3], m_fld[4], m_fld[5]};
                    m_blink = 1'b0; m_phase = P_COMMIT;
                end else if (s || u || d) begin
                    m_secs = 0; m_blink = 1'b1;
                    if (s) m_sel = (m_sel + 1) % 6;
                    else model_adjust(u ? 1 : -1);
                end else if (sec) begin
                    m_secs++;
                    if (m_secs >= TO) begin m_phase = P_IDLE; m_blink = 1'b0; end
                    else m_blink = ~m_blink;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic tick(input logic m, input logic s, input logic u,
                        input logic d, input logic sec);
        btn_mode = m; btn_sel = s; btn_up = u; btn_down = d; clk1sec = sec;
        @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0; clk1sec = 1'b0;
        model_step(m, s, u, d, sec);
    endtask

    task automatic enter_edit();
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (set_time !== 1'b0) begin fails++; $display("[TB] FAIL reset_set: got %b want 0", set_time); end
        checks++; if (bin_time !== 48'h0) begin fails++; $display("[TB] FAIL reset_bin: got %h want 0", bin_time); end
        checks++; if (edit_active !== 1'b0) begin fails++; $display("[TB] FAIL reset_active: got %b want 0", edit_active); end
        checks++; if (edit_field !== 3'd0) begin fails++; $display("[TB] FAIL reset_field: got %0d want 0", edit_field); end
        checks++; if (blink !== 1'b0) begin fails++; $display("[TB] FAIL reset_blink: got %b want 0", blink); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid_edit();
        logic sawSet;
        cur_time = tpack(30, 7, 4, 12, 0, 0);
        enter_edit();
        tick(0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        checks++; if (edit_active !== 1'b0) begin fails++; $display("[TB] FAIL midrst_active: got %b want 0", edit_active); end
        checks++; if (edit_field !== 3'd0) begin fails++; $display("[TB] FAIL midrst_field: got %0d want 0", edit_field); end
        checks++; if (blink !== 1'b0) begin fails++; $display("[TB] FAIL midrst_blink: got %b want 0", blink); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        sawSet = 1'b0;
        repeat (5) begin
            tick(0, 0, 0, 0, 0);
            sawSet = sawSet | set_time;
        end
        checks++; if (sawSet !== 1'b0) begin fails++; $display("[TB] FAIL midrst_nostrobe: got %b want 0", sawSet); end
        checks++; if (bin_time !== 48'h0) begin fails++; $display("[TB] FAIL midrst_bin: got %h want 0", bin_time); end
    endtask

    task automatic test_commit_basic();
        cur_time = tpack(21, 5, 30, 10, 20, 30);
        enter_edit();
        checks++; if (edit_active !== 1'b1) begin fails++; $display("[TB] FAIL basic_active: got %b want 1", edit_active); end
        checks++; if (blink !== 1'b1) begin fails++; $display("[TB] FAIL basic_blink: got %b want 1", blink); end
        repeat (5) tick(0, 1, 0, 0, 0);
        checks++; if (edit_field !== 3'd5) begin fails++; $display("[TB] FAIL basic_field: got %0d want 5", edit_field); end
        tick(0, 0, 1, 0, 0);
        checks++; if (set_time !== 1'b0) begin fails++; $display("[TB] FAIL basic_early: got %b want 0", set_time); end
        tick(1, 0, 0, 0, 0);
        checks++; if (set_time !== 1'b1) begin fails++; $display("[TB] FAIL basic_set: got %b want 1", set_time); end
        checks++; if (bin_time !== tpack(21, 5, 30, 10, 20, 31)) begin fails++; $display("[TB] FAIL basic_bin: got %h want %h", bin_time, tpack(21, 5, 30, 10, 20, 31)); end
        tick(0, 0, 0, 0, 0);
        checks++; if (set_time !== 1'b0) begin fails++; $display("[TB] FAIL basic_pulse: got %b want 0", set_time); end
        checks++; if (bin_time !== tpack(21, 5, 30, 10, 20, 31)) begin fails++; $display("[TB] FAIL basic_hold: got %h want %h", bin_time, tpack(21, 5, 30, 10, 20, 31)); end
        checks++; if (edit_active !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle: got %b want 0", edit_active); end
    endtask

    task automatic test_day_clamp();
        cur_time = tpack(24, 1, 31, 0, 0, 0);
        enter_edit();
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        checks++; if (bin_time !== tpack(24, 2, FEB24, 0, 0, 0)) begin fails++; $display("[TB] FAIL clamp_month: got %h want %h", bin_time, tpack(24, 2, FEB24, 0, 0, 0)); end
        tick(0, 0, 0, 0, 0);
        cur_time = tpack(24, 2, 29, 0, 0, 0);
        enter_edit();
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        checks++; if (bin_time !== tpack(25, 2, 28, 0, 0, 0)) begin fails++; $display("[TB] FAIL clamp_year: got %h want %h", bin_time, tpack(25, 2, 28, 0, 0, 0)); end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        cur_time = tpack(255, 1, 15, 0, 59, 0);
        enter_edit();
        tick(0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        checks++; if (bin_time !== tpack(0, 12, 15, 23, 0, 0)) begin fails++; $display("[TB] FAIL wrap_bin: got %h want %h", bin_time, tpack(0, 12, 15, 23, 0, 0)); end
        tick(0, 0, 0, 0, 0);
        cur_time = tpack(10, 0, 5, 0, 0, 70);
        enter_edit();
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        repeat (4) tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0);
        checks++; if (bin_time !== tpack(10, 1, 5, 0, 0, 0)) begin fails++; $display("[TB] FAIL snap_bin: got %h want %h", bin_time, tpack(10, 1, 5, 0, 0, 0)); end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        logic sawSet;
        sawSet = 1'b0;
        cur_time = tpack(40, 6, 6, 6, 6, 6);
        enter_edit();
        tick(0, 0, 0, 0, 1);
        checks++; if (blink !== 1'b0) begin fails++; $display("[TB] FAIL to_blink1: got %b want 0", blink); end
        tick(0, 0, 0, 0, 1);
        checks++; if (edit_active !== 1'b1) begin fails++; $display("[TB] FAIL to_early: got %b want 1", edit_active); end
        checks++; if (blink !== 1'b1) begin fails++; $display("[TB] FAIL to_blink2: got %b want 1", blink); end
        tick(0, 0, 0, 0, 1);
        sawSet = sawSet | set_time;
        checks++; if (edit_active !== 1'b0) begin fails++; $display("[TB] FAIL to_abort: got %b want 0", edit_active); end
        checks++; if (blink !== 1'b0) begin fails++; $display("[TB] FAIL to_blink_off: got %b want 0", blink); end
        enter_edit();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 1, 0, 1);
        checks++; if (blink !== 1'b1) begin fails++; $display("[TB] FAIL to_btn_blink: got %b want 1", blink); end
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        sawSet = sawSet | set_time;
        checks++; if (edit_active !== 1'b1) begin fails++; $display("[TB] FAIL to_cleared: got %b want 1", edit_active); end
        tick(0, 0, 0, 0, 1);
        sawSet = sawSet | set_time;
        checks++; if (edit_active !== 1'b0) begin fails++; $display("[TB] FAIL to_abort2: got %b want 0", edit_active); end
        repeat (2) begin
            tick(0, 0, 0, 0, 0);
            sawSet = sawSet | set_time;
        end
        checks++; if (sawSet !== 1'b0) begin fails++; $display("[TB] FAIL to_nostrobe: got %b want 0", sawSet); end
    endtask

    task automatic test_priority();
        cur_time = tpack(33, 3, 3, 3, 3, 3);
        enter_edit();
        tick(1, 0, 1, 0, 0);
        checks++; if (set_time !== 1'b1) begin fails++; $display("[TB] FAIL prio_set: got %b want 1", set_time); end
        checks++; if (bin_time !== tpack(33, 3, 3, 3, 3, 3)) begin fails++; $display("[TB] FAIL prio_mode: got %h want %h", bin_time, tpack(33, 3, 3, 3, 3, 3)); end
        tick(0, 0, 0, 0, 0);
        enter_edit();
        tick(0, 1, 1, 1, 0);
        checks++; if (edit_field !== 3'd1) begin fails++; $display("[TB] FAIL prio_sel: got %0d want 1", edit_field); end
        tick(0, 0, 1, 1, 0);
        tick(1, 0, 0, 0, 0);
        checks++; if (bin_time !== tpack(33, 4, 3, 3, 3, 3)) begin fails++; $display("[TB] FAIL prio_up: got %h want %h", bin_time, tpack(33, 4, 3, 3, 3, 3)); end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic m, s, u, d, sec;
        int nAct;
        for (int sess = 0; sess < 40; sess++) begin
            cur_time = tpack($urandom_range(0, 255), $urandom_range(0, 13), $urandom_range(0, 32),
                             $urandom_range(0, 25), $urandom_range(0, 61), $urandom_range(0, 61));
            nAct = $urandom_range(3, 25);
            for (int st = 0; st < nAct + 4; st++) begin
                m = 1'b0; s = 1'b0; u = 1'b0; d = 1'b0; sec = 1'b0;
                if (st == 0) m = (m_phase == P_IDLE);
                else if (st == nAct + 1) m = (m_phase == P_EDIT);
                else if (st >= 2 && st <= nAct) begin
                    s   = ($urandom_range(0, 3) == 0);
                    u   = ($urandom_range(0, 1) == 0);
                    d   = ($urandom_range(0, 1) == 0);
                    sec = ($urandom_range(0, 7) == 0);
                end
                tick(m, s, u, d, sec);
                checks++; if (set_time !== (m_phase == P_COMMIT)) begin fails++; $display("[TB] FAIL rnd_set s%0d c%0d: got %b want %b", sess, st, set_time, m_phase == P_COMMIT); end
                checks++; if (bin_time !== m_bin) begin fails++; $display("[TB] FAIL rnd_bin s%0d c%0d: got %h want %h", sess, st, bin_time, m_bin); end
                checks++; if (edit_active !== (m_phase == P_LOAD || m_phase == P_EDIT)) begin fails++; $display("[TB] FAIL rnd_active s%0d c%0d: got %b", sess, st, edit_active); end
                checks++; if (edit_field !== 3'(m_sel)) begin fails++; $display("[TB] FAIL rnd_field s%0d c%0d: got %0d want %0d", sess, st, edit_field, m_sel); end
                checks++; if (blink !== m_blink) begin fails++; $display("[TB] FAIL rnd_blink s%0d c%0d: got %b want %b", sess, st, blink, m_blink); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_edit();
        test_commit_basic();
        test_day_clamp();
        test_wrap();
        test_timeout();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
